rgb2hsv_stream_ctrl: RTL
========================

// Module: rgb2hsv_stream_ctrl
// PURPOSE
//  Stream sequencer for the fixed-latency, fully pipelined RGB->HSV core (s1..s8 chain).
//  Accepts 8-bit RGB pixels on a valid/ready input and launches them into the core.
//  Tracks in-flight pixels and the end-of-frame marker alongside the core.
//  Captures H/S/V results into an output FIFO. Credit-based admission means the core
//  never produces a result that has no FIFO space, so the core needs no stall input.
// PARAMETERS
//  LAT        8   core latency in cycles: launch register -> valid result on core_*_i
//  FIFO_DEPTH 16  output FIFO entries; power of 2, must be >= LAT
//  CNT_W      32  width of optional statistics counters
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   input pixel valid
//  in_ready    out  1   controller can accept pixel
//  in_r/g/b    in   8   unsigned RGB components
//  in_last     in   1   last pixel of frame
//  core_r/g/b  out  10  registered launch operands, zero-extended, to core
//  core_h_i    in   16  core hue result
//  core_s_i    in   10  core saturation result
//  core_v_i    in   10  core value result
//  out_valid   out  1   FIFO head valid
//  out_ready   in   1   downstream accepts head
//  out_h       out  16  hue of head entry
//  out_s/out_v out  10  saturation / value of head entry
//  out_last    out  1   head entry is last pixel of frame
//  busy        out  1   state != IDLE
//  frame_done  out  1   one-cycle pulse when DRAIN completes
// BEHAVIOUR
//  Reset (async, all regs): in_ready=0 while rst_n low, then 1. All other outputs 0.
//   State IDLE. Credits = FIFO_DEPTH. Valid pipe cleared. FIFO empty.
//  Accept: in_valid && in_ready. Next edge: core_r/g/b <= {2'b0,in_*}, vpipe[0] <= 1,
//   lpipe[0] <= in_last. Non-accepting cycles hold core_* and set vpipe[0] <= 0.
//  vpipe/lpipe: LAT-deep shift registers, advance every cycle; no stall.
//  Retire: when vpipe[LAT-1] is 1, core_*_i and lpipe[LAT-1] are written to the FIFO.
//   Min latency: accept edge -> out_valid = LAT+2 cycles (10 at default).
//  Credits: credits = FIFO_DEPTH - fifo_count - inflight. Kept as one counter:
//   -1 on accept, +1 on pop, both together leaves it unchanged.
//   in_ready = (credits != 0) && state != DRAIN.
//  FIFO: first-word fall-through registered outputs, out_* valid while out_valid.
//   Pop on out_valid && out_ready. Push and pop in one cycle at full or empty are both legal.
//   Overflow must be impossible; a push while full is an assertion failure.
//  FSM:
//   IDLE  -> RUN   on accept with in_last=0
//   IDLE  -> DRAIN on accept with in_last=1
//   RUN   -> DRAIN on accept with in_last=1
//   DRAIN -> IDLE  when inflight==0 && FIFO empty (last pop done); frame_done=1 that cycle.
//   DRAIN ignores in_valid (in_ready=0).
//  Reset mid-frame drops all in-flight and queued pixels. No output or frame_done follows.
//  Data is passed through bit-exact. No arithmetic on H/S/V.
// CONFIGURATION
//  RGB2HSV_STATS_EN defined: adds outputs pix_cnt[CNT_W-1:0] and stall_cnt[CNT_W-1:0].
//   pix_cnt increments on each pop. stall_cnt increments each cycle out_valid && !out_ready.
//   Both reset to 0 and wrap at 2^CNT_W.
//  RGB2HSV_STATS_EN undefined: ports and counters absent. Other behaviour identical.
// TESTING
//  T1 reset: after rst_n rises -> in_ready=1, out_valid=0, busy=0, frame_done=0.
//  T2 single pixel (80,128,54) last=1, accepted cycle 0 -> core_r/g/b = 80/128/54 at cycle 1.
//   out_valid rises at cycle 10 with out_last=1. in_ready=0 until IDLE.
//   frame_done pulses on the pop cycle.
//  T3 burst of 20 pixels with out_ready=0 -> exactly 16 accepted, then in_ready=0.
//   No loss. Raise out_ready -> 16 results in input order, then remaining 4 accepted.
//  T4 FIFO full plus continuous in_valid and out_ready=1 -> one accept and one pop per cycle.
//   Credits stay at 0/1 boundary, no overflow assertion.
//  T5 reset pulse with 5 pixels in flight and 3 queued -> all outputs 0 immediately.
//   No out_valid for 20 cycles after release.
//  T6 (STATS_EN) 4 pixels, out_ready held low 3 cycles while head valid -> pix_cnt=4, stall_cnt=3.

Source files
------------

// File: rtl/rgb2hsv_stream_ctrl.sv
// rgb2hsv_stream_ctrl: stream sequencer around a fixed-latency, fully pipelined
// RGB->HSV core. Pixels are admitted against a credit counter sized to the
// output FIFO, so every result the core produces is guaranteed a FIFO slot and
// the core itself never stalls.
// Optional feature macro: RGB2HSV_STATS_EN adds pix_cnt / stall_cnt counters.

// Overflow guard for the result FIFO, kept apart from the datapath.
module rgb2hsv_stream_ctrl_chk #(
   parameter int FIFO_DEPTH = 16,
   parameter int CW         = 5
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);
   // a push into a full FIFO is only legal when the head leaves in the same cycle
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == CW'(FIFO_DEPTH)) && !pop))
      else $error("rgb2hsv_stream_ctrl: result FIFO overflow");
endmodule

module rgb2hsv_stream_ctrl #(
   parameter int LAT        = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_r,
   input  logic [7:0]       in_g,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   output logic [9:0]       core_r,
   output logic [9:0]       core_g,
   output logic [9:0]       core_b,
   input  logic [15:0]      core_h_i,
   input  logic [9:0]       core_s_i,
   input  logic [9:0]       core_v_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_h,
   output logic [9:0]       out_s,
   output logic [9:0]       out_v,
   output logic             out_last,
   output logic             busy,
   output logic             frame_done
`ifdef RGB2HSV_STATS_EN
   ,
   output logic [CNT_W-1:0] pix_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   credits_r;
   logic [CW-1:0]   credits_nxt_s;
   logic            in_ready_r;
   logic            busy_r;

   logic [9:0]      core_r_r;
   logic [9:0]      core_g_r;
   logic [9:0]      core_b_r;
   logic [LAT-1:0]  vpipe_r;
   logic [LAT-1:0]  lpipe_r;

   logic [15:0]     mem_h_r [FIFO_DEPTH];
   logic [9:0]      mem_s_r [FIFO_DEPTH];
   logic [9:0]      mem_v_r [FIFO_DEPTH];
   logic            mem_l_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic            out_valid_r;
   logic [15:0]     out_h_r;
   logic [9:0]      out_s_r;
   logic [9:0]      out_v_r;
   logic            out_last_r;

   logic            accept_s;
   logic            push_s;
   logic            pop_s;
   logic [CW-1:0]   count_left_s;
   logic [AW-1:0]   rd_nxt_s;
   logic            drain_done_s;

   // handshakes, FIFO occupancy after the pop, next state and next credit count
   always_comb begin
      accept_s      = in_valid && in_ready_r;
      push_s        = vpipe_r[LAT-1];
      pop_s         = out_valid_r && out_ready;
      count_left_s  = count_r - {{AW{1'b0}}, pop_s};
      rd_nxt_s      = rd_ptr_r + AW'(pop_s);
      drain_done_s  = (state_r == DRAIN) && (vpipe_r == {LAT{1'b0}}) &&
                      (count_left_s == {CW{1'b0}});
      credits_nxt_s = credits_r;
      state_nxt_s   = state_r;

      case ({accept_s, pop_s})
         2'b10:   credits_nxt_s = credits_r - {{AW{1'b0}}, 1'b1};
         2'b01:   credits_nxt_s = credits_r + {{AW{1'b0}}, 1'b1};
         default: credits_nxt_s = credits_r;
      endcase

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = in_last ? DRAIN : RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (accept_s && in_last) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (drain_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // frame sequencing: state, admission credits and the registered ready/busy flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         credits_r  <= CW'(FIFO_DEPTH);
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         credits_r  <= credits_nxt_s;
         in_ready_r <= (credits_nxt_s != {CW{1'b0}}) && (state_nxt_s != DRAIN);
         busy_r     <= (state_nxt_s != IDLE);
      end
   end

   // launch registers toward the core plus the valid/last tags that travel with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_r_r <= 10'd0;
         core_g_r <= 10'd0;
         core_b_r <= 10'd0;
         vpipe_r  <= {LAT{1'b0}};
         lpipe_r  <= {LAT{1'b0}};
      end else begin
         if (accept_s) begin
            core_r_r <= {2'b00, in_r};
            core_g_r <= {2'b00, in_g};
            core_b_r <= {2'b00, in_b};
         end else begin
            core_r_r <= core_r_r;
            core_g_r <= core_g_r;
            core_b_r <= core_b_r;
         end
         vpipe_r <= {vpipe_r[LAT-2:0], accept_s};
         lpipe_r <= {lpipe_r[LAT-2:0], in_last && accept_s};
      end
   end

   // result storage: a retiring core result is written at the tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_h_r[i] <= 16'd0;
            mem_s_r[i] <= 10'd0;
            mem_v_r[i] <= 10'd0;
            mem_l_r[i] <= 1'b0;
         end
      end else begin
         if (push_s) begin
            mem_h_r[wr_ptr_r] <= core_h_i;
            mem_s_r[wr_ptr_r] <= core_s_i;
            mem_v_r[wr_ptr_r] <= core_v_i;
            mem_l_r[wr_ptr_r] <= lpipe_r[LAT-1];
         end else begin
            mem_h_r[wr_ptr_r] <= mem_h_r[wr_ptr_r];
            mem_s_r[wr_ptr_r] <= mem_s_r[wr_ptr_r];
            mem_v_r[wr_ptr_r] <= mem_v_r[wr_ptr_r];
            mem_l_r[wr_ptr_r] <= mem_l_r[wr_ptr_r];
         end
      end
   end

   // FIFO pointers and occupancy (occupancy includes the entry shown at the head)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_r + AW'(push_s);
         rd_ptr_r <= rd_nxt_s;
         count_r  <= count_left_s + {{AW{1'b0}}, push_s};
      end
   end

   // registered head: shows the oldest entry already stored, so a fresh write
   // becomes visible one cycle after it lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_h_r     <= 16'd0;
         out_s_r     <= 10'd0;
         out_v_r     <= 10'd0;
         out_last_r  <= 1'b0;
      end else begin
         if (count_left_s != {CW{1'b0}}) begin
            out_valid_r <= 1'b1;
            out_h_r     <= mem_h_r[rd_nxt_s];
            out_s_r     <= mem_s_r[rd_nxt_s];
            out_v_r     <= mem_v_r[rd_nxt_s];
            out_last_r  <= mem_l_r[rd_nxt_s];
         end else begin
            out_valid_r <= 1'b0;
            out_h_r     <= 16'd0;
            out_s_r     <= 10'd0;
            out_v_r     <= 10'd0;
            out_last_r  <= 1'b0;
         end
      end
   end

`ifdef RGB2HSV_STATS_EN
   logic [CNT_W-1:0] pix_cnt_r;
   logic [CNT_W-1:0] stall_cnt_r;

   // traffic statistics: pixels delivered and cycles the head was held back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_r   <= {CNT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (pop_s) begin
            pix_cnt_r <= pix_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            pix_cnt_r <= pix_cnt_r;
         end
         if (out_valid_r && !out_ready) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign pix_cnt   = pix_cnt_r;
   assign stall_cnt = stall_cnt_r;
`endif

   rgb2hsv_stream_ctrl_chk #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CW         (CW)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .count (count_r)
   );

   assign in_ready   = in_ready_r;
   assign busy       = busy_r;
   assign core_r     = core_r_r;
   assign core_g     = core_g_r;
   assign core_b     = core_b_r;
   assign out_valid  = out_valid_r;
   assign out_h      = out_h_r;
   assign out_s      = out_s_r;
   assign out_v      = out_v_r;
   assign out_last   = out_last_r;
   // completion is flagged in the very cycle the final entry is popped
   assign frame_done = drain_done_s;

endmodule
